// File: rtl/cpu_mem_responder.sv
// Memory responder that sits beside a small CPU.
// A loader streams beats into instruction (imem) and data (dmem) memories,
// then the block pulses start, enables the CPU and serves its fetches and
// data accesses until the CPU halts.
//
// Ports:
//   clock, reset             single rising-edge clock, synchronous active-high reset
//   i_addr / i_datain        instruction fetch address / registered instruction word
//   d_addr, d_dataout, d_we  data address, write data, write enable
//   d_datain                 registered read data (read-first on same-address write)
//   halt                     CPU halted; returns the block to IDLE from RUN
//   ld_valid/ld_ready        loader handshake; ld_sel picks imem (0) or dmem (1)
//   ld_addr, ld_data         loader write address and data; ld_last ends the load
//   start, enable            one-cycle start pulse and CPU enable
//   fetch_count              instruction reads served in RUN, saturating
module cpu_mem_responder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_datain,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_dataout,
  input  logic              d_we,
  output logic [DATA_W-1:0] d_datain,
  input  logic              halt,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_sel,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              start,
  output logic              enable,
  output logic [15:0]       fetch_count
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StLoad, StStart, StRun} state_e;

  state_e state_q, state_d;

  // No reset on the arrays: contents survive reset.
  logic [DATA_W-1:0] imem_q [Depth];
  logic [DATA_W-1:0] dmem_q [Depth];

  logic [DATA_W-1:0] i_datain_q, i_datain_d;
  logic [DATA_W-1:0] d_datain_q, d_datain_d;
  logic [15:0]       fetch_count_q, fetch_count_d;

  logic              ld_accept;
  logic              imem_we;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_waddr;
  logic [DATA_W-1:0] dmem_wdata;

  assign ld_ready    = (state_q == StIdle) || (state_q == StLoad);
  assign start       = (state_q == StStart);
  assign enable      = (state_q == StStart) || (state_q == StRun);
  assign ld_accept   = ld_valid && ld_ready;
  assign i_datain    = i_datain_q;
  assign d_datain    = d_datain_q;
  assign fetch_count = fetch_count_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StLoad: begin
        if (ld_accept) state_d = ld_last ? StStart : StLoad;
      end
      StStart: state_d = StRun;
      StRun: begin
        if (halt) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    // Read registers only carry data while the next state is RUN, so they read
    // zero in IDLE/LOAD/START and drop to zero on the halt edge.
    i_datain_d = '0;
    d_datain_d = '0;
    if (state_d == StRun) begin
      i_datain_d = imem_q[i_addr];
    end
    if ((state_q == StRun) && (state_d == StRun)) begin
      d_datain_d = dmem_q[d_addr];
    end

    fetch_count_d = fetch_count_q;
    if (state_d == StStart) begin
      fetch_count_d = '0;
    end else if ((state_q == StRun) && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end
  end

  // Loader writes and CPU writes never coincide: ld_ready is low in RUN.
  always_comb begin
    imem_we    = ld_accept && !ld_sel && !reset;
    dmem_we    = !reset && ((ld_accept && ld_sel) || ((state_q == StRun) && d_we));
    dmem_waddr = (state_q == StRun) ? d_addr : ld_addr;
    dmem_wdata = (state_q == StRun) ? d_dataout : ld_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      i_datain_q    <= '0;
      d_datain_q    <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      i_datain_q    <= i_datain_d;
      d_datain_q    <= d_datain_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Nonblocking writes give read-first behaviour for a same-address access.
  always_ff @(posedge clock) begin
    if (imem_we) imem_q[ld_addr] <= ld_data;
    if (dmem_we) dmem_q[dmem_waddr] <= dmem_wdata;
  end

endmodule
